calc_seq_ctrl: RTL

Operation sequencer for the calculator front end. It walks the user through entering operand A, entering operand B, and selecting an operator using the push buttons. It drives the enable and clear lines of the operand-A and operand-B latch banks, launches the ALU, and supervises the ALU with a timeout. It also selects what the seven-segment display shows. It sits between the debounce stage and the numA/numB latches and the ALU.

---
 rtl/calc_seq_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/calc_seq_ctrl.sv
// Calculator operation sequencer: walks operand A / operand B / operator entry,
// launches the ALU, supervises it with a timeout and selects the display source.
module calc_seq_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] sw,
  input  logic       pb_next,
  input  logic       pb_clr,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       en_a,
  output logic       en_b,
  output logic       clr_ab,
  output logic [1:0] op,
  output logic       alu_start,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ENT_A  = 3'd1;
  localparam logic [2:0] ENT_B  = 3'd2;
  localparam logic [2:0] ENT_OP = 3'd3;
  localparam logic [2:0] EXEC   = 3'd4;
  localparam logic [2:0] WAIT   = 3'd5;
  localparam logic [2:0] SHOW   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  // [1:0] synchronize the button, [2] holds the previous level for edge detect
  logic [2:0] nxt_pipe, clr_pipe;
  logic       nxt, clr;
  logic [2:0] st_q, st_d;
  logic [7:0] wait_cnt;
  logic       unused_sw;

  assign unused_sw = ^sw[8:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nxt_pipe <= '0;
      clr_pipe <= '0;
      nxt      <= 1'b0;
      clr      <= 1'b0;
    end else begin
      nxt_pipe <= {nxt_pipe[1:0], pb_next};
      clr_pipe <= {clr_pipe[1:0], pb_clr};
      nxt      <= nxt_pipe[1] & ~nxt_pipe[2];
      clr      <= clr_pipe[1] & ~clr_pipe[2];
    end
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:   if (nxt) st_d = ENT_A;
      ENT_A:  if (nxt) st_d = ENT_B;
      ENT_B:  if (nxt) st_d = ENT_OP;
      ENT_OP: if (nxt) st_d = EXEC;
      EXEC:   st_d = WAIT;
      WAIT: begin
        // a completion in the last allowed cycle beats the timeout
        if (alu_done)               st_d = alu_err ? ERR : SHOW;
        else if (wait_cnt == TO_LAST) st_d = ERR;
      end
      SHOW:   if (nxt) st_d = ENT_A;
      ERR:    if (nxt) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (clr) st_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      wait_cnt <= '0;
      op       <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == EXEC)      wait_cnt <= '0;
      else if (st_q == WAIT) wait_cnt <= wait_cnt + 8'd1;
      if (st_q == ENT_OP && nxt && !clr) op <= sw[1:0];
    end
  end

  assign state     = st_q;
  assign en_a      = (st_q == ENT_A) & sw[9];
  assign en_b      = (st_q == ENT_B) & sw[9];
  assign clr_ab    = (st_q == IDLE) | ((st_q == SHOW) & nxt);
  assign alu_start = (st_q == EXEC);
  assign busy      = (st_q == EXEC) | (st_q == WAIT);

  always_comb begin
    case (st_q)
      ENT_B, ENT_OP: disp_sel = 2'd1;
      SHOW:          disp_sel = 2'd2;
      ERR:           disp_sel = 2'd3;
      default:       disp_sel = 2'd0;
    endcase
  end

endmodule
